// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the HI/LO registers.
// mult/multu/div/divu compute their result at acceptance and commit it to
// HI/LO after a fixed busy window; mthi/mtlo write HI/LO immediately.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        kill,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d;
    logic [31:0] lo_n_q, lo_n_d;
    logic        wr_q, wr_d;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_abs, b_abs, b_abs_safe, b_safe;
    logic [31:0] sq_mag, sr_mag, sdiv_q, sdiv_r;
    logic [31:0] udiv_q, udiv_r;
    logic        accept;

    // Products and quotients for the operands currently on A/B.
    // Signed division runs on magnitudes and re-applies signs, so the
    // 0x80000000 / -1 case yields 0x80000000 without relying on overflow.
    always_comb begin
        a_sx       = $signed({{32{A[31]}}, A});
        b_sx       = $signed({{32{B[31]}}, B});
        prod_s     = a_sx * b_sx;
        prod_u     = {32'd0, A} * {32'd0, B};
        a_abs      = A[31] ? (32'd0 - A) : A;
        b_abs      = B[31] ? (32'd0 - B) : B;
        b_abs_safe = (B == '0) ? 32'd1 : b_abs;
        b_safe     = (B == '0) ? 32'd1 : B;
        sq_mag     = a_abs / b_abs_safe;
        sr_mag     = a_abs % b_abs_safe;
        sdiv_q     = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
        sdiv_r     = A[31] ? (32'd0 - sr_mag) : sr_mag;
        udiv_q     = A / b_safe;
        udiv_r     = A % b_safe;
    end

    assign accept = (state_q == IDLE) && start && !kill;

    // Next-state: accept new ops in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            hi_n_d  = prod_s[63:32];
                            lo_n_d  = prod_s[31:0];
                            wr_d    = 1'b1;
                            cnt_d   = 32'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            hi_n_d  = prod_u[63:32];
                            lo_n_d  = prod_u[31:0];
                            wr_d    = 1'b1;
                            cnt_d   = 32'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            hi_n_d  = sdiv_r;
                            lo_n_d  = sdiv_q;
                            wr_d    = (B != '0);
                            cnt_d   = 32'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            hi_n_d  = udiv_r;
                            lo_n_d  = udiv_q;
                            wr_d    = (B != '0);
                            cnt_d   = 32'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start and kill are ignored here; the running op completes.
                if (cnt_q == 32'd1) begin
                    if (wr_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and HI/LO registers; reset aborts any running op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            wr_q    <= wr_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed + randomized bench for md_unit with a queue-based scoreboard.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic        kill;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t sb[$];

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .op   (op),
        .start(start),
        .kill (kill),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model returning {hi, lo}; uses 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        r   = '0;
        case (o)
            3'd1: r = 64'(sa * sbv);
            3'd2: r = ua * ub;
            3'd3: r = {32'(sa % sbv), 32'(sa / sbv)};
            3'd4: r = {32'(ua % ub), 32'(ua / ub)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one op, optionally with kill at issue, a kill pulse or an
    // ignored mthi at a given busy cycle; then score the outcome.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input logic [31:0] eh, input logic [31:0] el,
                          input int unsigned ncyc, input logic kill0,
                          input int kill_at, input int ign_at);
        exp_t        e;
        logic [31:0] hi0, lo0;
        int          n;
        e.tag = tag; e.hi = eh; e.lo = el; e.cycles = ncyc;
        sb.push_back(e);
        hi0 = hi;
        lo0 = lo;
        op = o; A = a; B = b; start = 1'b1; kill = kill0;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; kill = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 1) begin
                chk({tag, " hold_hi"}, hi, hi0);
                chk({tag, " hold_lo"}, lo, lo0);
            end
            kill = (n == kill_at);
            if (n == ign_at) begin
                start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(posedge clk); #1;
        end
        kill = 1'b0; start = 1'b0; op = 3'd0;
        e = sb.pop_front();
        chk({e.tag, " cycles"}, 32'(n), 32'(e.cycles));
        chk({e.tag, " hi"}, hi, e.hi);
        chk({e.tag, " lo"}, lo, e.lo);
    endtask

    initial begin
        logic [63:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; A = '0; B = '0;
        #2 reset = 1'b0;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'h1111_1111, 32'h2222_2222, "op0", 32'h0, 32'h0, 0, 1'b0, 0, 0);
        run_op(3'd7, 32'h1111_1111, 32'h2222_2222, "op7", 32'h0, 32'h0, 0, 1'b0, 0, 0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu", 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b0, 0, 0);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 0, 0);
        run_op(3'd4, 32'd7, 32'd2, "divu", 32'h1, 32'h3, 10, 1'b0, 0, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 32'h0, 32'h8000_0000, 10, 1'b0, 0, 0);

        run_op(3'd5, 32'h1234, 32'd0, "mthi", 32'h1234, 32'h8000_0000, 0, 1'b0, 0, 0);
        run_op(3'd6, 32'h5678, 32'd0, "mtlo", 32'h1234, 32'h5678, 0, 1'b0, 0, 0);
        run_op(3'd4, 32'd99, 32'd0, "divu by0", 32'h1234, 32'h5678, 10, 1'b0, 0, 0);
        run_op(3'd3, 32'hFFFF_FF00, 32'd0, "div by0", 32'h1234, 32'h5678, 10, 1'b0, 0, 0);

        run_op(3'd1, 32'd5, 32'd5, "mult killed", 32'h1234, 32'h5678, 0, 1'b1, 0, 0);
        run_op(3'd5, 32'hAAAA, 32'd0, "mthi killed", 32'h1234, 32'h5678, 0, 1'b1, 0, 0);
        run_op(3'd1, 32'd6, 32'd7, "mult kill-in-run", 32'h0, 32'd42, 5, 1'b0, 2, 3);

        for (int i = 0; i < 8; i++) begin
            ro = 3'(1 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb = rb >> $urandom_range(16, 30);
            if (rb == '0) rb = 32'd3;
            m = model(ro, ra, rb);
            run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro), m[63:32], m[31:0],
                   (ro <= 3'd2) ? 5 : 10, 1'b0, 0, 0);
        end

        // Force hi/lo nonzero so the async clear is observable.
        run_op(3'd1, 32'h0001_0003, 32'h0001_0005, "pre-reset mult", 32'h1, 32'h0008_000F, 5, 1'b0, 0, 0);

        op = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post rst busy", {31'd0, busy}, 32'd0);
        chk("post rst hi", hi, 32'd0);
        chk("post rst lo", lo, 32'd0);

        run_op(3'd1, 32'h0001_0000, 32'h0001_0000, "mult after rst", 32'h1, 32'h0, 5, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
